imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 8, meaning log2 of instruction-memory depth in 32-bit words.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000, meaning byte address of the first loaded word.
REQ-003 SHALL have port clock  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port resetN  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a program load.
REQ-006 SHALL have port length  input  DEPTH_LOG2+1  word count N, sampled only when start is accepted.
REQ-007 SHALL have port loadValid  input  1  loadData holds a valid word.
REQ-008 SHALL have port loadData  input  32  instruction word being streamed in.
REQ-009 SHALL have port loadReady  output  1  loader accepts a word this cycle.
REQ-010 SHALL have port memWriteEnable  output  1  instruction-memory write strobe.
REQ-011 SHALL have port memAddr  output  32  instruction-memory byte address.
REQ-012 SHALL have port memWriteData  output  32  instruction-memory write data.
REQ-013 SHALL have port cpuHold  output  1  holds the DataPath PC and register writes while high.
REQ-014 SHALL have port done  output  1  one-cycle pulse on successful load completion.
REQ-015 SHALL have port error  output  1  sticky load-failure flag, cleared by the next accepted start.

Function
REQ-016 SHALL implement states IDLE, LOAD, CHECK, FINISH.
REQ-017 SHALL accept start only in IDLE; start in any other state SHALL be ignored.
REQ-018 On accepted start with 1 <= N <= 2^DEPTH_LOG2: clear error, zero word index, go to LOAD.
REQ-019 On accepted start with N = 0: go directly to FINISH with no memory writes.
REQ-020 On accepted start with N > 2^DEPTH_LOG2: set error, stay in IDLE, perform no writes, leave cpuHold unchanged.
REQ-021 SHALL assert loadReady only in LOAD; a word transfers when loadValid and loadReady are both high on a rising edge.
REQ-022 Each transfer SHALL produce, in the following cycle, memWriteEnable=1, memAddr=BASE_ADDR+4*index, memWriteData=the word (latency 1 cycle, registered outputs).
REQ-023 memWriteEnable SHALL be 0 in every cycle that follows no transfer; loadValid gaps SHALL stall without side effects.
REQ-024 Index SHALL increment by 1 per transfer; after the Nth transfer, loadReady SHALL drop the next cycle and the state SHALL advance to CHECK if IMEM_LOADER_CHECKSUM_EN is defined, else to FINISH.
REQ-025 cpuHold SHALL be 1 from the cycle after an accepted start through the FINISH cycle, then 0 starting the cycle after FINISH.
REQ-026 FINISH SHALL last one cycle, assert done for that cycle, then return to IDLE.
REQ-027 memAddr SHALL wrap modulo 2^32 with no error if BASE_ADDR+4*index overflows.

Reset
REQ-028 On resetN low, state SHALL immediately become IDLE, index 0, loadReady 0, memWriteEnable 0, memAddr 0, memWriteData 0, done 0, error 0, cpuHold 1.
REQ-029 Reset asserted mid-LOAD SHALL abandon the load; already-written words remain in memory; cpuHold SHALL stay 1 until a later load completes.

Configuration
REQ-030 With IMEM_LOADER_CHECKSUM_EN defined: in CHECK, loadReady=1 for exactly one extra word, compared to the XOR of all N loaded words; that word SHALL not be written to memory; on match go to FINISH; on mismatch set error, keep cpuHold=1, return to IDLE without done.
REQ-031 Without IMEM_LOADER_CHECKSUM_EN: CHECK SHALL be unreachable, no extra word is consumed, and error is set only per REQ-020.

Verification
REQ-032 Reset release, no start -> cpuHold=1, loadReady=0, memWriteEnable=0, done=0, error=0.
REQ-033 start with N=3, words 20080005, 20090007, 01095020 streamed back-to-back -> writes at addresses 0, 4, 8 one cycle after each transfer; done pulses once; cpuHold=0 the following cycle.
REQ-034 N=2 with loadValid low for 3 cycles between words -> exactly 2 writes, to addresses 0 and 4, no write during the gap.
REQ-035 start with N=2^DEPTH_LOG2+1 (257 at default) -> error=1, no writes, state stays IDLE; subsequent start with N=1 clears error.
REQ-036 resetN pulsed low after 2 of 4 words -> outputs at reset values immediately; next start with N=1 loads at address 0.
REQ-037 With IMEM_LOADER_CHECKSUM_EN, N=2, words 00000001, 00000002, checksum 00000004 -> error=1, no done, cpuHold stays 1; repeating with checksum 00000003 -> done pulses, cpuHold falls.

Source files
------------

// File: rtl/imem_loader.sv
// Streams a program into instruction memory while holding the CPU, then releases it.
// Optional trailing XOR checksum word is enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int unsigned DEPTH_LOG2 = 8,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic                  clock,
  input  logic                  resetN,
  input  logic                  start,
  input  logic [DEPTH_LOG2:0]   length,
  input  logic                  loadValid,
  input  logic [31:0]           loadData,
  output logic                  loadReady,
  output logic                  memWriteEnable,
  output logic [31:0]           memAddr,
  output logic [31:0]           memWriteData,
  output logic                  cpuHold,
  output logic                  done,
  output logic                  error
);

  localparam int unsigned LW    = DEPTH_LOG2 + 1;
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LOAD   = 2'd1;
  localparam logic [1:0] CHECK  = 2'd2;
  localparam logic [1:0] FINISH = 2'd3;

  logic [1:0]    state;
  logic [1:0]    state_next;
  logic [LW-1:0] index;
  logic [LW-1:0] length_q;
  logic          xfer;
  logic          start_ok;
  logic          start_bad;
  logic          chk_fail;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0]   csum;
`endif

  // State register
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and transfer decode
  always_comb begin
    state_next = state;
    xfer       = 1'b0;
    start_ok   = 1'b0;
    start_bad  = 1'b0;
    chk_fail   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (length > LW'(DEPTH)) begin
            start_bad = 1'b1;
          end else if (length == LW'(0)) begin
            start_ok   = 1'b1;
            state_next = FINISH;
          end else begin
            start_ok   = 1'b1;
            state_next = LOAD;
          end
        end
      end
      LOAD: begin
        xfer = loadValid & loadReady;
        if (xfer && (index == (length_q - LW'(1)))) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_next = CHECK;
`else
          state_next = FINISH;
`endif
        end
      end
      CHECK: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        // Checksum word is consumed here but never written to memory
        if (loadValid && loadReady) begin
          if (loadData == csum) begin
            state_next = FINISH;
          end else begin
            chk_fail   = 1'b1;
            state_next = IDLE;
          end
        end
`else
        state_next = IDLE;
`endif
      end
      FINISH: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Index, length capture and registered outputs
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      index          <= '0;
      length_q       <= '0;
      loadReady      <= 1'b0;
      memWriteEnable <= 1'b0;
      memAddr        <= '0;
      memWriteData   <= '0;
      done           <= 1'b0;
      error          <= 1'b0;
      cpuHold        <= 1'b1;
    end else begin
      loadReady      <= (state_next == LOAD) || (state_next == CHECK);
      memWriteEnable <= xfer;
      done           <= (state_next == FINISH);

      if (start_ok) begin
        index    <= '0;
        length_q <= length;
      end else if (xfer) begin
        index <= index + LW'(1);
      end

      // Address arithmetic wraps naturally modulo 2^32
      if (xfer) begin
        memAddr      <= BASE_ADDR + (32'(index) << 2);
        memWriteData <= loadData;
      end

      if (start_bad || chk_fail) begin
        error <= 1'b1;
      end else if (start_ok) begin
        error <= 1'b0;
      end

      if (state == FINISH) begin
        cpuHold <= 1'b0;
      end else if (start_ok) begin
        cpuHold <= 1'b1;
      end
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  // Running XOR of every word written during LOAD
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      csum <= '0;
    end else if (start_ok) begin
      csum <= '0;
    end else if (xfer) begin
      csum <= csum ^ loadData;
    end
  end
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Directed, table-driven bench for imem_loader at default parameters.
module tb_imem_loader;

  localparam int unsigned DL = 8;

  logic          clock = 1'b0;
  logic          resetN = 1'b0;
  logic          start = 1'b0;
  logic [DL:0]   length = '0;
  logic          loadValid = 1'b0;
  logic [31:0]   loadData = '0;
  logic          loadReady;
  logic          memWriteEnable;
  logic [31:0]   memAddr;
  logic [31:0]   memWriteData;
  logic          cpuHold;
  logic          done;
  logic          error;

  int n_pass = 0;
  int n_tot  = 0;

  imem_loader #(.DEPTH_LOG2(DL), .BASE_ADDR(32'h0000_0000)) dut (
    .clock(clock), .resetN(resetN), .start(start), .length(length),
    .loadValid(loadValid), .loadData(loadData), .loadReady(loadReady),
    .memWriteEnable(memWriteEnable), .memAddr(memAddr), .memWriteData(memWriteData),
    .cpuHold(cpuHold), .done(done), .error(error)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        st;
    logic [DL:0] len;
    logic        v;
    logic [31:0] d;
    logic        rdy;
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic        hold;
    logic        dn;
    logic        err;
  } vec_t;

  vec_t tbl[19];

  function automatic vec_t mk(input logic st, input int len, input logic v, input logic [31:0] d,
                              input logic rdy, input logic we, input logic [31:0] addr,
                              input logic [31:0] data, input logic hold, input logic dn,
                              input logic err);
    vec_t r;
    r.st = st; r.len = (DL+1)'(len); r.v = v; r.d = d;
    r.rdy = rdy; r.we = we; r.addr = addr; r.data = data;
    r.hold = hold; r.dn = dn; r.err = err;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Drive inputs on the falling edge, sample 1 time unit after the rising edge
  task automatic step(input logic st, input int len, input logic v, input logic [31:0] d);
    @(negedge clock);
    start = st; length = (DL+1)'(len); loadValid = v; loadData = d;
    @(posedge clock);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic rdy, input logic we,
                            input logic hold, input logic dn, input logic err);
    check({tag, ".rdy"},  32'(loadReady),      32'(rdy));
    check({tag, ".we"},   32'(memWriteEnable), 32'(we));
    check({tag, ".hold"}, 32'(cpuHold),        32'(hold));
    check({tag, ".done"}, 32'(done),           32'(dn));
    check({tag, ".err"},  32'(error),          32'(err));
  endtask

  initial begin
    // Back-to-back N=3 load
    tbl[0]  = mk(1, 3, 0, 32'h0,        1, 0, 32'h0, 32'h0,        1, 0, 0);
    tbl[1]  = mk(0, 0, 1, 32'h20080005, 1, 1, 32'h0, 32'h20080005, 1, 0, 0);
    tbl[2]  = mk(0, 0, 1, 32'h20090007, 1, 1, 32'h4, 32'h20090007, 1, 0, 0);
    tbl[3]  = mk(0, 0, 1, 32'h01095020, 0, 1, 32'h8, 32'h01095020, 1, 1, 0);
    tbl[4]  = mk(0, 0, 0, 32'h0,        0, 0, 32'h0, 32'h0,        0, 0, 0);
    // N=2 with a 3-cycle gap; start during LOAD is ignored
    tbl[5]  = mk(1, 2, 0, 32'h0,        1, 0, 32'h0, 32'h0,        1, 0, 0);
    tbl[6]  = mk(0, 0, 1, 32'hAAAA0001, 1, 1, 32'h0, 32'hAAAA0001, 1, 0, 0);
    tbl[7]  = mk(1, 5, 0, 32'hDEADBEEF, 1, 0, 32'h0, 32'h0,        1, 0, 0);
    tbl[8]  = mk(0, 0, 0, 32'h0,        1, 0, 32'h0, 32'h0,        1, 0, 0);
    tbl[9]  = mk(0, 0, 0, 32'h0,        1, 0, 32'h0, 32'h0,        1, 0, 0);
    tbl[10] = mk(0, 0, 1, 32'hAAAA0002, 0, 1, 32'h4, 32'hAAAA0002, 1, 1, 0);
    tbl[11] = mk(0, 0, 0, 32'h0,        0, 0, 32'h0, 32'h0,        0, 0, 0);
    // Oversize length: error, no load, hold unchanged; then N=1 clears error
    tbl[12] = mk(1, 257, 0, 32'h0,      0, 0, 32'h0, 32'h0,        0, 0, 1);
    tbl[13] = mk(0, 0, 1, 32'h55555555, 0, 0, 32'h0, 32'h0,        0, 0, 1);
    tbl[14] = mk(1, 1, 0, 32'h0,        1, 0, 32'h0, 32'h0,        1, 0, 0);
    tbl[15] = mk(0, 0, 1, 32'h12345678, 0, 1, 32'h0, 32'h12345678, 1, 1, 0);
    tbl[16] = mk(0, 0, 0, 32'h0,        0, 0, 32'h0, 32'h0,        0, 0, 0);
    // N=0 goes straight to FINISH
    tbl[17] = mk(1, 0, 1, 32'hCAFEF00D, 0, 0, 32'h0, 32'h0,        1, 1, 0);
    tbl[18] = mk(0, 0, 0, 32'h0,        0, 0, 32'h0, 32'h0,        0, 0, 0);

    repeat (2) @(posedge clock);
    @(negedge clock);
    resetN = 1'b1;
    step(0, 0, 0, 32'h0);
    check_outs("rst", 0, 0, 1, 0, 0);

`ifndef IMEM_LOADER_CHECKSUM_EN
    for (int i = 0; i < 19; i++) begin
      step(tbl[i].st, int'(tbl[i].len), tbl[i].v, tbl[i].d);
      check_outs($sformatf("v%0d", i), tbl[i].rdy, tbl[i].we, tbl[i].hold, tbl[i].dn, tbl[i].err);
      if (tbl[i].we) begin
        check($sformatf("v%0d.addr", i), memAddr,      tbl[i].addr);
        check($sformatf("v%0d.data", i), memWriteData, tbl[i].data);
      end
    end

    // Full-depth load: last word lands at byte 0x3FC
    step(1, 256, 0, 32'h0);
    check("full.rdy", 32'(loadReady), 32'd1);
    for (int k = 0; k < 256; k++) begin
      step(0, 0, 1, 32'(k) ^ 32'hF0F0_0000);
      check($sformatf("full%0d.addr", k), memAddr, 32'(k) << 2);
      check($sformatf("full%0d.we", k), 32'(memWriteEnable), 32'd1);
    end
    check("full.done", 32'(done), 32'd1);
    step(0, 0, 0, 32'h0);
    check("full.hold", 32'(cpuHold), 32'd0);
`else
    // Wrong checksum: error, no done, hold stays high
    step(1, 2, 0, 32'h0);
    step(0, 0, 1, 32'h1);
    step(0, 0, 1, 32'h2);
    check_outs("ck1.w2", 1, 1, 1, 0, 0);
    check("ck1.addr", memAddr, 32'h4);
    step(0, 0, 1, 32'h4);
    check_outs("ck1.bad", 0, 0, 1, 0, 1);
    step(0, 0, 0, 32'h0);
    check_outs("ck1.idle", 0, 0, 1, 0, 1);
    // Correct checksum
    step(1, 2, 0, 32'h0);
    check_outs("ck2.st", 1, 0, 1, 0, 0);
    step(0, 0, 1, 32'h1);
    step(0, 0, 1, 32'h2);
    step(0, 0, 1, 32'h3);
    check_outs("ck2.fin", 0, 0, 1, 1, 0);
    step(0, 0, 0, 32'h0);
    check_outs("ck2.idle", 0, 0, 0, 0, 0);
`endif

    // Asynchronous reset after 2 of 4 words
    step(1, 4, 0, 32'h0);
    step(0, 0, 1, 32'h11111111);
    step(0, 0, 1, 32'h22222222);
    @(negedge clock);
    loadValid = 1'b0;
    #2 resetN = 1'b0;
    #1;
    check_outs("ar", 0, 0, 1, 0, 0);
    check("ar.addr", memAddr, 32'h0);
    check("ar.data", memWriteData, 32'h0);
    @(negedge clock);
    resetN = 1'b1;
    step(0, 0, 0, 32'h0);
    check_outs("ar.idle", 0, 0, 1, 0, 0);
    step(1, 1, 0, 32'h0);
    step(0, 0, 1, 32'h33333333);
    check("ar.we", 32'(memWriteEnable), 32'd1);
    check("ar.addr1", memAddr, 32'h0);
    check("ar.data1", memWriteData, 32'h33333333);
`ifdef IMEM_LOADER_CHECKSUM_EN
    step(0, 0, 1, 32'h33333333);
`endif
    check("ar.done", 32'(done), 32'd1);
    step(0, 0, 0, 32'h0);
    check("ar.hold", 32'(cpuHold), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
